// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Optional misalignment checking in dmem_resp is enabled with DMEM_ALIGN_CHK_EN.
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } dmem_state_t;

  typedef enum logic {
    DMEM_OP_RD = 1'b0,
    DMEM_OP_WR = 1'b1
  } dmem_op_t;

  // Counter preload: the request cycle itself is the first stall cycle.
  function automatic logic [DMEM_LAT_W-1:0] lat_load(input int lat);
    return DMEM_LAT_W'(lat - 1);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM, one 32-bit word per location, no reset.
// Read data is registered and only updates on a read enable.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] mem_q [2**ADDR_W];
  logic [DMEM_WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder for the MEM stage: stalls the pipeline for the access latency.
// Define DMEM_ALIGN_CHK_EN to flag and suppress misaligned accesses through o_MEM_mem_Err.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [31:0]            i_MEM_mem_DmemAddr,
  input  logic [DMEM_WORD_W-1:0] i_MEM_mem_DmemDataW,
  input  logic                   i_MEM_mem_MemRead,
  input  logic                   i_MEM_mem_MemWrite,
  output logic [DMEM_WORD_W-1:0] o_MEM_mem_DmemDataR,
  output logic                   o_MEM_mem_Stall,
  output logic                   o_MEM_mem_Err
);

  localparam logic [DMEM_LAT_W-1:0] RD_CNT = lat_load(RD_LAT);
  localparam logic [DMEM_LAT_W-1:0] WR_CNT = lat_load(WR_LAT);

  dmem_state_t              state_q, state_d;
  logic [DMEM_LAT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]        word_q, word_d;
  logic [DMEM_WORD_W-1:0]   wdata_q, wdata_d;
  dmem_op_t                 op_q, op_d;
  logic                     mis_q, mis_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     err_q, err_d;

  logic                     req;
  dmem_op_t                 req_op;
  logic [ADDR_W-1:0]        req_word;
  logic                     req_mis;
  logic [DMEM_LAT_W-1:0]    req_cnt;

  logic                     done_entry;
  dmem_op_t                 cur_op;
  logic                     cur_mis;
  logic                     stall;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DMEM_WORD_W-1:0]   ram_wdata;
  logic                     ram_we;
  logic                     ram_re;
  logic [DMEM_WORD_W-1:0]   ram_rdata;
  logic                     unused_addr_bits;

  assign req      = i_MEM_mem_MemRead | i_MEM_mem_MemWrite;
  assign req_op   = i_MEM_mem_MemWrite ? DMEM_OP_WR : DMEM_OP_RD;
  assign req_word = i_MEM_mem_DmemAddr[ADDR_W+1:2];
  assign req_cnt  = (req_op == DMEM_OP_WR) ? WR_CNT : RD_CNT;

`ifdef DMEM_ALIGN_CHK_EN
  assign req_mis = is_misaligned(i_MEM_mem_DmemAddr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  // Upper address bits wrap onto the array; byte offset only matters with the align check.
  assign unused_addr_bits = ^{i_MEM_mem_DmemAddr[31:ADDR_W+2], i_MEM_mem_DmemAddr[1:0]};

  // In IDLE the RAM is fed straight from the request so a 1-cycle access can commit at once.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    mis_d      = mis_q;
    rd_valid_d = rd_valid_q;
    err_d      = 1'b0;
    done_entry = 1'b0;
    cur_op     = op_q;
    cur_mis    = mis_q;
    ram_addr   = word_q;
    ram_wdata  = wdata_q;
    stall      = 1'b0;

    case (state_q)
      IDLE: begin
        stall     = req;
        cur_op    = req_op;
        cur_mis   = req_mis;
        ram_addr  = req_word;
        ram_wdata = i_MEM_mem_DmemDataW;
        if (req) begin
          word_d  = req_word;
          wdata_d = i_MEM_mem_DmemDataW;
          op_d    = req_op;
          mis_d   = req_mis;
          cnt_d   = req_cnt;
          if (req_cnt == '0) begin
            state_d    = DONE;
            done_entry = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q <= DMEM_LAT_W'(1)) begin
          cnt_d      = '0;
          state_d    = DONE;
          done_entry = 1'b1;
        end else begin
          cnt_d = cnt_q - DMEM_LAT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (done_entry) begin
      err_d = cur_mis;
      if (cur_op == DMEM_OP_RD) begin
        rd_valid_d = !cur_mis;
      end
    end
  end

  // Gating with nrst keeps a write from landing on a clock edge seen while reset is held.
  assign ram_we = done_entry && (cur_op == DMEM_OP_WR) && !cur_mis && nrst;
  assign ram_re = done_entry && (cur_op == DMEM_OP_RD) && !cur_mis && nrst;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      op_q       <= DMEM_OP_RD;
      mis_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      mis_q      <= mis_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register holds the last good read; rd_valid_q forces zero after reset or a bad read.
  assign o_MEM_mem_DmemDataR = rd_valid_q ? ram_rdata : '0;
  assign o_MEM_mem_Stall     = stall & nrst;
  assign o_MEM_mem_Err       = err_q;

endmodule
